// File: rtl/fb_fill_engine_if.sv
// Command handshake and framebuffer port A signals of the rectangle fill engine.
// slave: engine side; master: command source / BRAM side.
interface fb_fill_engine_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [9:0]  cmd_w;
   logic [8:0]  cmd_h;
   logic [7:0]  cmd_color;
   logic        busy;
   logic        done;
   logic        bram_clka;
   logic        bram_rsta;
   logic        bram_ena;
   logic [3:0]  bram_wea;
   logic [18:0] bram_addra;
   logic [31:0] bram_dina;

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
      output cmd_ready, busy, done,
      output bram_clka, bram_rsta, bram_ena, bram_wea, bram_addra, bram_dina
   );

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
      input  cmd_ready, busy, done,
      input  bram_clka, bram_rsta, bram_ena, bram_wea, bram_addra, bram_dina
   );
endinterface

// File: rtl/fb_fill_engine.sv
// Clipped rectangle fill into the 640x480 RGB332 framebuffer, one 32-bit word per cycle.
// First write two cycles after command acceptance; one command in flight, cmd_ready only in IDLE.
module fb_fill_engine #(
   parameter int FB_WIDTH      = 640,
   parameter int FB_HEIGHT     = 480,
   parameter int WORDS_PER_ROW = FB_WIDTH / 4
) (
   input  logic              clk,
   input  logic              resetn,
   fb_fill_engine_if.slave   fif
);
   typedef enum logic [1:0] {IDLE, CLIP, WRITE, DONE} state_t;

   state_t      state;
   logic [9:0]  x_q, w_q;
   logic [8:0]  y_q, h_q;
   logic [7:0]  color_q;
   logic [7:0]  fc_q, lc_q, col;
   logic [8:0]  row, ye_m1_q;
   logic [16:0] row_base;
   logic [3:0]  fm_q, lm_q;
   logic        rdy_q, busy_q, done_q, ena_q;
   logic [3:0]  wea_q;
   logic [18:0] addr_q;
   logic [31:0] din_q;

   function automatic logic [3:0] word_mask(input logic [7:0] c, f, l, input logic [3:0] fm, lm);
      logic [3:0] m;
      m = 4'hF;
      if (c == f) m = m & fm;
      if (c == l) m = m & lm;
      return m;
   endfunction

   function automatic logic [18:0] byte_addr(input logic [16:0] base, input logic [7:0] c);
      return {base + {9'd0, c}, 2'b00};
   endfunction

   // Clip arithmetic on the latched command, used only in CLIP.
   logic [10:0] x_end, y_end, xe_c, ye_c, xe_m1;
   logic [7:0]  fc_c, lc_c;
   logic [8:0]  ye_m1_c;
   logic [3:0]  fm_c, lm_c;
   logic [16:0] base_c;
   logic        empty_c;

   always_comb begin
      x_end   = {1'b0, x_q} + {1'b0, w_q};
      y_end   = {2'b0, y_q} + {2'b0, h_q};
      xe_c    = (x_end > 11'(FB_WIDTH))  ? 11'(FB_WIDTH)  : x_end;
      ye_c    = (y_end > 11'(FB_HEIGHT)) ? 11'(FB_HEIGHT) : y_end;
      empty_c = (w_q == '0) || (h_q == '0) ||
                ({1'b0, x_q} >= 11'(FB_WIDTH)) || ({2'b0, y_q} >= 11'(FB_HEIGHT));
      xe_m1   = xe_c - 11'd1;
      fc_c    = x_q[9:2];
      lc_c    = 8'(xe_m1 >> 2);
      ye_m1_c = 9'(ye_c - 11'd1);
      fm_c    = 4'hF << x_q[1:0];
      lm_c    = 4'hF >> (2'd3 - xe_m1[1:0]);
      base_c  = ({8'd0, y_q} << 7) + ({8'd0, y_q} << 5);
   end

   // Word after the one currently on the port; outputs are registered one word ahead.
   logic        last_col, last_word;
   logic [7:0]  nx_col;
   logic [8:0]  nx_row;
   logic [16:0] nx_base;

   always_comb begin
      last_col  = (col == lc_q);
      last_word = last_col && (row == ye_m1_q);
      nx_col    = last_col ? fc_q : col + 8'd1;
      nx_row    = last_col ? row + 9'd1 : row;
      nx_base   = last_col ? row_base + 17'(WORDS_PER_ROW) : row_base;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         color_q  <= '0;
         fc_q     <= '0;
         lc_q     <= '0;
         col      <= '0;
         row      <= '0;
         ye_m1_q  <= '0;
         row_base <= '0;
         fm_q     <= '0;
         lm_q     <= '0;
         rdy_q    <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ena_q    <= 1'b0;
         wea_q    <= '0;
         addr_q   <= '0;
         din_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fif.cmd_valid && rdy_q) begin
                  x_q     <= fif.cmd_x;
                  y_q     <= fif.cmd_y;
                  w_q     <= fif.cmd_w;
                  h_q     <= fif.cmd_h;
                  color_q <= fif.cmd_color;
                  rdy_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= CLIP;
               end
            end
            CLIP: begin
               if (empty_c) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  fc_q     <= fc_c;
                  lc_q     <= lc_c;
                  ye_m1_q  <= ye_m1_c;
                  fm_q     <= fm_c;
                  lm_q     <= lm_c;
                  col      <= fc_c;
                  row      <= y_q;
                  row_base <= base_c;
                  ena_q    <= 1'b1;
                  wea_q    <= word_mask(fc_c, fc_c, lc_c, fm_c, lm_c);
                  addr_q   <= byte_addr(base_c, fc_c);
                  din_q    <= {4{color_q}};
                  state    <= WRITE;
               end
            end
            WRITE: begin
               if (last_word) begin
                  ena_q  <= 1'b0;
                  wea_q  <= '0;
                  addr_q <= '0;
                  din_q  <= '0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  col      <= nx_col;
                  row      <= nx_row;
                  row_base <= nx_base;
                  wea_q    <= word_mask(nx_col, fc_q, lc_q, fm_q, lm_q);
                  addr_q   <= byte_addr(nx_base, nx_col);
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               rdy_q  <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Gating with resetn silences the port in the very cycle reset is asserted.
   assign fif.cmd_ready  = rdy_q & resetn;
   assign fif.busy       = busy_q & resetn;
   assign fif.done       = done_q & resetn;
   assign fif.bram_clka  = clk;
   assign fif.bram_rsta  = ~resetn;
   assign fif.bram_ena   = ena_q & resetn;
   assign fif.bram_wea   = resetn ? wea_q  : '0;
   assign fif.bram_addra = resetn ? addr_q : '0;
   assign fif.bram_dina  = resetn ? din_q  : '0;
endmodule

// File: tb/tb_fb_fill_engine.sv
// Randomized and directed fills checked against a pixel-level model of the framebuffer writes.
module tb_fb_fill_engine;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   fb_fill_engine_if fif();
   fb_fill_engine dut (.clk(clk), .resetn(resetn), .fif(fif));

   typedef struct { logic [18:0] addr; logic [3:0] wea; } wr_t;
   wr_t exp_q[$];

   int checks = 0;
   int failures = 0;
   logic [18:0] first_addr, last_addr;
   logic [3:0]  first_wea, last_wea;
   int n_writes;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Walk every visible pixel of the rectangle and group them by framebuffer word.
   task automatic build_exp(input int x, y, w, h);
      int xe, ye, cur, word;
      logic [3:0] m;
      exp_q.delete();
      if (w == 0 || h == 0 || x >= 640 || y >= 480) return;
      xe = (x + w > 640) ? 640 : x + w;
      ye = (y + h > 480) ? 480 : y + h;
      for (int r = y; r < ye; r++) begin
         cur = -1;
         m = '0;
         for (int px = x; px < xe; px++) begin
            word = r * 160 + px / 4;
            if (word != cur && cur >= 0) begin
               exp_q.push_back('{addr: 19'(cur * 4), wea: m});
               m = '0;
            end
            cur = word;
            m[px % 4] = 1'b1;
         end
         exp_q.push_back('{addr: 19'(cur * 4), wea: m});
      end
   endtask

   task automatic run_cmd(input int x, y, w, h, input logic [7:0] color, input bit hold);
      int idx, n;
      bit done_seen;
      build_exp(x, y, w, h);
      n = exp_q.size();
      @(negedge clk);
      fif.cmd_valid = 1'b1;
      fif.cmd_x = 10'(x); fif.cmd_y = 9'(y); fif.cmd_w = 10'(w); fif.cmd_h = 9'(h);
      fif.cmd_color = color;
      check("ready_idle", 96'(fif.cmd_ready), 96'd1);
      @(posedge clk);
      #1;
      if (hold) begin
         fif.cmd_x = 10'($urandom); fif.cmd_y = 9'($urandom); fif.cmd_w = 10'($urandom);
         fif.cmd_h = 9'($urandom); fif.cmd_color = 8'($urandom);
      end else begin
         fif.cmd_valid = 1'b0;
      end
      idx = 0;
      n_writes = 0;
      done_seen = 0;
      for (int cyc = 1; cyc <= n + 10 && !done_seen; cyc++) begin
         @(negedge clk);
         if (cyc == 1)
            check("clip_cycle", 96'({fif.busy, fif.bram_ena, fif.cmd_ready, fif.done}), 96'(4'b1000));
         if (fif.bram_ena) begin
            if (idx < n) begin
               check("write", {32'(cyc), 9'd0, fif.bram_addra, fif.bram_wea, fif.bram_dina},
                     {32'(idx + 2), 9'd0, exp_q[idx].addr, exp_q[idx].wea, {4{color}}});
               if (idx == 0) begin first_addr = fif.bram_addra; first_wea = fif.bram_wea; end
               last_addr = fif.bram_addra;
               last_wea  = fif.bram_wea;
            end else begin
               check("extra_write", 96'(idx), 96'(n - 1));
            end
            idx++;
            n_writes++;
         end
         if (fif.done) begin
            done_seen = 1;
            check("done_timing", {32'(cyc), 32'(idx), 31'd0, fif.cmd_ready},
                  {32'(n + 2), 32'(n), 32'd0});
         end
      end
      if (!done_seen) begin
         check("done_timeout", 96'd0, 96'd1);
      end else begin
         @(negedge clk);
         fif.cmd_valid = 1'b0;
         #1;
         check("after_done", 96'({fif.cmd_ready, fif.done, fif.busy, fif.bram_ena}), 96'(4'b1000));
      end
   endtask

   initial begin
      fif.cmd_valid = 1'b0;
      fif.cmd_x = '0; fif.cmd_y = '0; fif.cmd_w = '0; fif.cmd_h = '0; fif.cmd_color = '0;
      repeat (3) @(negedge clk);
      check("in_reset", 96'({fif.cmd_ready, fif.busy, fif.done, fif.bram_ena, fif.bram_rsta,
                             fif.bram_wea, fif.bram_addra, fif.bram_dina}), 96'(59'd1 << 55));
      resetn = 1'b1;
      @(negedge clk);
      check("after_reset", 96'({fif.cmd_ready, fif.busy, fif.done, fif.bram_ena, fif.bram_rsta}),
            96'(5'b10000));

      run_cmd(5, 3, 1, 1, 8'hA5, 0);
      check("tp_1x1", {32'(n_writes), 41'd0, first_addr, first_wea}, {32'd1, 41'd0, 19'd1924, 4'b0010});
      run_cmd(2, 0, 7, 2, 8'h1C, 0);
      check("tp_rect_first", {first_addr, first_wea}, {19'd0, 4'b1100});
      check("tp_rect_last", {32'(n_writes), last_addr, last_wea}, {32'd6, 19'd648, 4'b0001});
      run_cmd(636, 478, 10, 5, 8'h3C, 0);
      check("tp_clip", {32'(n_writes), first_addr, last_addr, last_wea},
            {32'd2, 19'd306556, 19'd307196, 4'b1111});
      run_cmd(10, 10, 0, 3, 8'h11, 0);
      check("tp_w0", 96'(n_writes), 96'd0);
      run_cmd(700, 5, 4, 4, 8'h22, 1);
      check("tp_x700", 96'(n_writes), 96'd0);
      run_cmd(1, 470, 639, 10, 8'hE3, 1);
      check("tp_bottom", {32'(n_writes), last_addr, last_wea}, {32'd1600, 19'd307196, 4'b1111});

      for (int i = 0; i < 30; i++) begin
         run_cmd(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60)),
                 int'($urandom_range(0, 6)), 8'($urandom), bit'($urandom_range(0, 1)));
      end

      // Reset in the middle of a large fill.
      @(negedge clk);
      fif.cmd_valid = 1'b1;
      fif.cmd_x = 10'd0; fif.cmd_y = 9'd0; fif.cmd_w = 10'd640; fif.cmd_h = 9'd40;
      @(posedge clk);
      #1 fif.cmd_valid = 1'b0;
      repeat (50) @(negedge clk);
      check("mid_fill_active", 96'({fif.busy, fif.bram_ena}), 96'(2'b11));
      resetn = 1'b0;
      #1;
      check("reset_cycle", 96'({fif.bram_ena, fif.bram_wea, fif.done, fif.busy, fif.cmd_ready}), 96'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_hold", 96'({fif.bram_ena, fif.done, fif.busy, fif.bram_rsta}), 96'(4'b0001));
      end
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_reset", 96'({fif.cmd_ready, fif.busy, fif.done, fif.bram_ena}), 96'(4'b1000));
      end
      run_cmd(637, 0, 3, 2, 8'h5A, 0);
      check("recover", {32'(n_writes), first_addr, first_wea}, {32'd2, 19'd636, 4'b1110});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
